// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 string sequencer.
//  - LCD command byte constants used during init and line addressing
//  - State encodings for the top-level sequencer and the byte writer
//  - Helpers to pick an init command and a character out of the 256-bit string
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET_8B_2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON        = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC      = 8'h06;
  localparam logic [7:0] LCD_CLEAR          = 8'h01;
  localparam logic [7:0] LCD_LINE1_ADDR     = 8'h80;
  localparam logic [7:0] LCD_LINE2_ADDR     = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_LINE1_ADDR,
    ST_LINE1_CHARS,
    ST_LINE2_ADDR,
    ST_LINE2_CHARS,
    ST_FINISH
  } seq_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } wr_state_e;

  // Init sequence in transmit order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0: cmd = LCD_FUNC_SET_8B_2L;
      2'd1: cmd = LCD_DISP_ON;
      2'd2: cmd = LCD_ENTRY_INC;
      2'd3: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

  // pos 0..31: 0 = line 1 column 0 (bits 255:248), 31 = line 2 column 15 (bits 7:0).
  function automatic logic [7:0] char_at(input logic [255:0] str, input logic [4:0] pos);
    logic [255:0] shifted;
    shifted = str << {pos, 3'b000};
    return shifted[255:248];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus transfer: SETUP (1 cycle, e=0), PULSE (E_PULSE_CYCLES, e=1),
// HOLD (CMD_WAIT_CYCLES or CLEAR_WAIT_CYCLES, e=0). rs/data stay stable for the
// whole transfer and after it until the next one.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          start a transfer; taken when idle or in the final HOLD cycle
//   rs, byte_in  register select and data byte for the transfer
//   long_wait    use CLEAR_WAIT_CYCLES for HOLD instead of CMD_WAIT_CYCLES
//   ack          1-cycle pulse on the last HOLD cycle
//   lcd_e, lcd_rs, lcd_data  LCD bus pins
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYCLES    = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
  parameter int unsigned CNT_W             = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] byte_in,
  input  logic       long_wait,
  output logic       ack,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic             hold_done;

  assign hold_done = (state_q == WR_HOLD) &&
                     (cnt_q == (long_q ? LONG_LAST : SHORT_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    ack     = hold_done;

    unique case (state_q)
      WR_IDLE: ;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end
      WR_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_HOLD: begin
        if (hold_done) state_d = WR_IDLE;
        else           cnt_d   = cnt_q + 1'b1;
      end
    endcase

    // Accepting in the final HOLD cycle makes the next SETUP follow with no gap.
    if (req && (state_q == WR_IDLE || hold_done)) begin
      state_d = WR_SETUP;
      cnt_d   = '0;
      rs_d    = rs;
      data_d  = byte_in;
      long_d  = long_wait;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WR_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign lcd_e    = (state_q == WR_PULSE);
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_string_sequencer.sv
// HD44780 2x16 controller: power-up delay, 8-bit init (0x38,0x0C,0x06,0x01),
// then on each accepted start writes 0x80, 16 line-1 chars, 0xC0, 16 line-2
// chars from a string latched at acceptance.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          write request, honoured only while ready=1
//   ascii_string   32 chars, line 1 col 0 in bits [255:248]
//   ready          init complete and no write in progress
//   busy           write in progress
//   done           1-cycle pulse when the write finishes
//   lcd_e, lcd_rs, lcd_rw, lcd_data  LCD bus pins (write only)
module lcd_string_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned E_PULSE_CYCLES    = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] ascii_string,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data
);

  localparam int unsigned MAX_WAIT = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ?
                                     POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [255:0]     string_q, string_d;

  logic       wr_req, wr_rs, wr_long, wr_ack;
  logic [7:0] wr_byte;

  // Every transition that issues a byte does so in the writer's ack cycle
  // (or while it is idle), so back-to-back bytes have no dead cycle.
  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    idx_d     = idx_q;
    string_d  = string_q;
    wr_req    = 1'b0;
    wr_rs     = 1'b0;
    wr_byte   = '0;
    wr_long   = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          wr_req  = 1'b1;
          wr_byte = init_cmd(2'd0);
          idx_d   = '0;
          state_d = ST_INIT;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (wr_ack) begin
          if (idx_q == 4'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            wr_req  = 1'b1;
            wr_byte = init_cmd(idx_d[1:0]);
            wr_long = (idx_d == 4'd3);
          end
        end
      end
      ST_IDLE, ST_FINISH: begin
        ready = 1'b1;
        done  = (state_q == ST_FINISH);
        if (start) begin
          string_d = ascii_string;
          wr_req   = 1'b1;
          wr_byte  = LCD_LINE1_ADDR;
          state_d  = ST_LINE1_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LINE1_ADDR: begin
        busy = 1'b1;
        if (wr_ack) begin
          idx_d   = '0;
          wr_req  = 1'b1;
          wr_rs   = 1'b1;
          wr_byte = char_at(string_q, 5'd0);
          state_d = ST_LINE1_CHARS;
        end
      end
      ST_LINE1_CHARS: begin
        busy = 1'b1;
        if (wr_ack) begin
          wr_req = 1'b1;
          if (idx_q == 4'd15) begin
            wr_byte = LCD_LINE2_ADDR;
            state_d = ST_LINE2_ADDR;
          end else begin
            idx_d   = idx_q + 4'd1;
            wr_rs   = 1'b1;
            wr_byte = char_at(string_q, {1'b0, idx_d});
          end
        end
      end
      ST_LINE2_ADDR: begin
        busy = 1'b1;
        if (wr_ack) begin
          idx_d   = '0;
          wr_req  = 1'b1;
          wr_rs   = 1'b1;
          wr_byte = char_at(string_q, 5'd16);
          state_d = ST_LINE2_CHARS;
        end
      end
      ST_LINE2_CHARS: begin
        busy = 1'b1;
        if (wr_ack) begin
          if (idx_q == 4'd15) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            wr_req  = 1'b1;
            wr_rs   = 1'b1;
            wr_byte = char_at(string_q, {1'b1, idx_d});
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PWRUP;
      pwr_cnt_q <= '0;
      idx_q     <= '0;
      string_q  <= '0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      idx_q     <= idx_d;
      string_q  <= string_d;
    end
  end

  lcd_byte_writer #(
    .E_PULSE_CYCLES   (E_PULSE_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES),
    .CNT_W            (CNT_W)
  ) u_writer (
    .clk      (clk),
    .rst      (rst),
    .req      (wr_req),
    .rs       (wr_rs),
    .byte_in  (wr_byte),
    .long_wait(wr_long),
    .ack      (wr_ack),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data)
  );

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_string_sequencer.sv
// Bench for lcd_string_sequencer with short timing parameters.
module tb_lcd_string_sequencer;

  localparam int P  = 20;
  localparam int E  = 2;
  localparam int CW = 5;
  localparam int CL = 30;
  localparam int NB       = 1 + E + CW;           // normal byte period
  localparam int INIT_LEN = 3 * NB + 1 + E + CL;  // four init bytes
  localparam int WR_LEN   = 34 * NB;              // one full string write

  localparam logic [255:0] S1 = "JEDEC ID:       MFR20 TYP20 C15 ";
  localparam logic [255:0] S2 = "SCRAMBLE TEST 01line two ok 1234";
  localparam logic [255:0] S3 = "0123456789ABCDEFfedcba9876543210";
  localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] ascii_string = '0;
  logic         ready, busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]   lcd_data;

  lcd_string_sequencer #(
    .POWERUP_CYCLES   (P),
    .E_PULSE_CYCLES   (E),
    .CMD_WAIT_CYCLES  (CW),
    .CLEAR_WAIT_CYCLES(CL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ascii_string(ascii_string),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data    (lcd_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_BOOT, M_IDLE, M_WRITE, M_FIN} mmode_t;
  mmode_t       m_mode = M_BOOT;
  int           m_rel = 0;
  bit           m_valid = 1'b0;
  logic [255:0] m_str = '0;
  logic         m_hold_rs = 1'b0;
  logic [7:0]   m_hold_d = '0;

  function automatic logic [7:0] char_of(input logic [255:0] s, input int i);
    logic [255:0] t;
    t = s >> (8 * (31 - i));
    return t[7:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_mode  = M_BOOT;
      m_rel   = 0;
    end else if (m_valid) begin
      case (m_mode)
        M_BOOT: begin
          m_rel++;
          if (m_rel == P + INIT_LEN) begin
            m_mode = M_IDLE; m_rel = 0; m_hold_rs = 1'b0; m_hold_d = 8'h01;
          end
        end
        M_IDLE, M_FIN: begin
          if (start) begin
            m_mode = M_WRITE; m_rel = 0; m_str = ascii_string;
          end else begin
            m_mode = M_IDLE;
          end
        end
        M_WRITE: begin
          m_rel++;
          if (m_rel == WR_LEN) begin
            m_mode = M_FIN; m_rel = 0; m_hold_rs = 1'b1; m_hold_d = char_of(m_str, 31);
          end
        end
      endcase
    end
  end

  logic       x_e, x_rs, x_rdy, x_bsy, x_dn;
  logic [7:0] x_d;
  int         x_k, x_o, x_r;

  always @(negedge clk) begin
    if (m_valid) begin
      x_e = 0; x_rs = 0; x_d = '0; x_rdy = 0; x_bsy = 0; x_dn = 0;
      case (m_mode)
        M_BOOT: begin
          if (m_rel >= P) begin
            x_r = m_rel - P;
            if (x_r >= 3 * NB) begin x_k = 3; x_o = x_r - 3 * NB; end
            else begin x_k = x_r / NB; x_o = x_r % NB; end
            x_d = INIT_CMDS[x_k];
            x_e = (x_o >= 1 && x_o <= E);
          end
        end
        M_IDLE: begin x_rdy = 1; x_rs = m_hold_rs; x_d = m_hold_d; end
        M_FIN:  begin x_rdy = 1; x_dn = 1; x_rs = m_hold_rs; x_d = m_hold_d; end
        M_WRITE: begin
          x_bsy = 1;
          x_k = m_rel / NB; x_o = m_rel % NB;
          x_e = (x_o >= 1 && x_o <= E);
          if (x_k == 0)       x_d = 8'h80;
          else if (x_k == 17) x_d = 8'hC0;
          else begin
            x_rs = 1;
            x_d  = char_of(m_str, (x_k < 17) ? x_k - 1 : x_k - 2);
          end
        end
      endcase
      chk("lcd_e", 32'(lcd_e), 32'(x_e));
      chk("lcd_rs", 32'(lcd_rs), 32'(x_rs));
      chk("lcd_rw", 32'(lcd_rw), 32'(1'b0));
      chk("lcd_data", 32'(lcd_data), 32'(x_d));
      chk("ready", 32'(ready), 32'(x_rdy));
      chk("busy", 32'(busy), 32'(x_bsy));
      chk("done", 32'(done), 32'(x_dn));
    end
  end

  // ---------------- bus capture ----------------
  logic       prev_e = 1'b0;
  logic [8:0] cap[$];
  int         n_done = 0;

  always @(negedge clk) begin
    if (lcd_e === 1'b1 && prev_e !== 1'b1) cap.push_back({lcd_rs, lcd_data});
    if (done === 1'b1) n_done++;
    prev_e = lcd_e;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk); #1;
    chk("reset_outputs", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data, ready, busy, done}), 32'd0);
    tick();
    rst = 1'b0;
    cap.delete();
    n_done = 0;
  endtask

  // Called in the first cycle after reset release; optional start poke at cycle poke.
  task automatic expect_boot(input int poke);
    int n;
    logic [8:0] want [4];
    want = '{9'h038, 9'h00C, 9'h006, 9'h001};
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 300) begin
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("ready_rise_cycles", 32'(n), 32'd77);
    chk("init_byte_count", 32'(cap.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk("init_byte", 32'(cap[i]), 32'(want[i]));
    tick();
  endtask

  task automatic check_burst(input string l1, input string l2);
    logic [8:0] want;
    chk("burst_len", 32'(cap.size()), 32'd34);
    for (int i = 0; i < 34 && i < cap.size(); i++) begin
      if (i == 0)       want = 9'h080;
      else if (i == 17) want = 9'h0C0;
      else if (i < 17)  want = {1'b1, l1[i-1]};
      else              want = {1'b1, l2[i-18]};
      chk("burst_byte", 32'(cap[i]), 32'(want));
    end
  endtask

  // Called at a cycle where ready=1; start is accepted at the next edge.
  task automatic write_and_check(input logic [255:0] s, input string l1, input string l2,
                                 input bit scramble, input int poke);
    int n;
    cap.delete();
    ascii_string = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    n_done = 0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      if (scramble) ascii_string = {$urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom};
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", 32'(n), 32'd272);
    tick();
    chk("done_pulses", 32'(n_done), 32'd1);
    check_burst(l1, l2);
  endtask

  initial begin
    int n;
    repeat (2) tick();

    // power-up and init
    do_reset();
    expect_boot(-1);

    // basic write
    repeat (3) tick();
    write_and_check(S1, "JEDEC ID:       ", "MFR20 TYP20 C15 ", 1'b0, -1);

    // input string changing every cycle after acceptance
    repeat (2) tick();
    write_and_check(S2, "SCRAMBLE TEST 01", "line two ok 1234", 1'b1, -1);
    ascii_string = S1;

    // start during INIT and mid-write are ignored
    do_reset();
    expect_boot(40);
    repeat (2) tick();
    write_and_check(S1, "JEDEC ID:       ", "MFR20 TYP20 C15 ", 1'b0, 100);
    repeat (30) tick();
    chk("no_second_burst", 32'(cap.size()), 32'd34);

    // reset during line-2 character 5
    ascii_string = S1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m_mode == M_WRITE && m_rel == 23 * NB + 1) && n < 400) begin
      tick();
      n++;
    end
    chk("mid_write_busy", 32'(busy), 32'd1);
    do_reset();
    expect_boot(-1);

    // back-to-back start in the done cycle
    repeat (2) tick();
    ascii_string = S1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (m_mode != M_FIN && n < 400) begin
      tick();
      n++;
    end
    chk("done_at_finish", 32'(done), 32'd1);
    write_and_check(S3, "0123456789ABCDEF", "fedcba9876543210", 1'b0, -1);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_string_sequencer.md
Name: lcd_string_sequencer

Overview:
- Controller that initialises an HD44780-compatible 2x16 character LCD in 8-bit mode, then streams the 32-character ASCII string from hex_to_ascii to the panel on request.
- Sits between hex_to_ascii (the 256-bit string source) and the LCD pins.
- Owns all LCD bus timing, power-up delay and command/data sequencing.

Parameters:
- POWERUP_CYCLES, 750000, idle cycles after reset before the first command (15 ms at 50 MHz).
- E_PULSE_CYCLES, 12, cycles lcd_e is held high per transfer (min 1).
- CMD_WAIT_CYCLES, 2000, post-pulse wait for normal commands and data writes (40 us).
- CLEAR_WAIT_CYCLES, 82000, post-pulse wait after the clear-display command (1.64 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to write ascii_string to the LCD.
- ascii_string  in  256  32 characters; bits [255:248] = line 1 column 0, [135:128] = line 1 column 15, [127:120] = line 2 column 0, [7:0] = line 2 column 15.
- ready  out  1  high when init is complete and no write is in progress; start is accepted only when high.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last character's wait completes.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  constant 0 (write only).
- lcd_data  out  8  LCD data bus.

Behaviour:
- Reset: all outputs 0 (lcd_e, lcd_rs, lcd_rw, lcd_data, ready, busy, done). FSM enters PWRUP and the counter clears.
- Reset asserted mid-transfer: outputs return to reset values at the next edge, and the full init sequence reruns.
- States:
  - PWRUP: wait POWERUP_CYCLES.
  - INIT: send 0x38, 0x0C, 0x06, 0x01 in order.
  - IDLE: ready=1.
  - LINE1_ADDR: command 0x80.
  - LINE1_CHARS: 16 data bytes.
  - LINE2_ADDR: command 0xC0.
  - LINE2_CHARS: 16 data bytes.
  - FINISH: done=1 for 1 cycle, then IDLE.
- Per-byte transfer (all bytes):
  - SETUP: 1 cycle, lcd_rs and lcd_data valid, lcd_e=0.
  - PULSE: E_PULSE_CYCLES cycles with lcd_e=1.
  - HOLD: lcd_e=0, lcd_rs and lcd_data unchanged, for CMD_WAIT_CYCLES (CLEAR_WAIT_CYCLES after 0x01).
  - Byte period = 1 + E_PULSE_CYCLES + wait.
  - The next byte's SETUP starts on the cycle after HOLD ends.
- start accepted when ready=1 && start=1:
  - ascii_string is latched that cycle.
  - ready drops and busy rises on the next cycle.
  - Later changes to ascii_string do not affect the current write.
- start while ready=0 (PWRUP, INIT or busy) is ignored, not queued.
- Character index counter runs 0..15 per line, byte = latched[255-8*(16*line+idx) -: 8]. Line and index wrap-around must not skip or repeat a character.
- Total write = 34 byte periods.
- busy falls and ready rises in the same cycle as the done pulse.
- The string is not re-sent automatically; each refresh requires a new start.
- Wait counters are sized to hold max(POWERUP_CYCLES, CLEAR_WAIT_CYCLES). All counts are exact; no off-by-one slack is permitted.

Decomposition:
- Package lcd_pkg holds:
  - command constants LCD_FUNC_SET_8B_2L=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY_INC=8'h06, LCD_CLEAR=8'h01, LCD_LINE1_ADDR=8'h80, LCD_LINE2_ADDR=8'hC0;
  - the sequencer state encoding.
- Sub-module lcd_byte_writer performs one SETUP/PULSE/HOLD transfer:
  - inputs: req, rs, byte, long_wait;
  - output: ack, a 1-cycle pulse at the end of HOLD.
- The top FSM sequences bytes through this sub-module.

Test Plan (bench overrides POWERUP=20, E_PULSE=2, CMD_WAIT=5, CLEAR_WAIT=30):
- Reset then idle:
  - lcd_e stays 0 for 20 cycles.
  - Bytes 0x38, 0x0C, 0x06, 0x01 then appear, each rs=0, lcd_e high exactly 2 cycles.
  - Gap after 0x01 is 30 cycles.
  - ready rises after the last wait.
- start with string "JEDEC ID:       " / "MFR20 TYP20 C15 ":
  - Captured sequence: 0x80, 16 line-1 chars (rs=1), 0xC0, 16 line-2 chars in order.
  - done pulses once, 34*(1+2+5) cycles after busy rises.
- ascii_string changed every cycle after start acceptance: captured bytes still match the value latched at acceptance.
- start pulsed during INIT and again mid-write: both ignored; exactly one 34-byte burst follows a later accepted start.
- rst asserted during line-2 character 5:
  - Next cycle all outputs are 0.
  - The full power-up and init sequence repeats before ready=1.
- Back-to-back start in the cycle ready returns high: accepted, busy=1 next cycle, second burst correct.
